// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the 1RW SRAM controller: FSM state encoding and
// the CSb/WEb/OEb pin patterns driven in each state.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_RD_ISSUE   = 2'd2,
    ST_RD_CAPTURE = 2'd3
  } state_t;

  typedef struct packed {
    logic csb;
    logic web;
    logic oeb;
  } sram_pins_t;

  localparam sram_pins_t PINS_IDLE  = '{csb: 1'b1, web: 1'b1, oeb: 1'b1};
  localparam sram_pins_t PINS_WRITE = '{csb: 1'b0, web: 1'b0, oeb: 1'b1};
  localparam sram_pins_t PINS_READ  = '{csb: 1'b0, web: 1'b1, oeb: 0};

  // Both read states present identical pins; the second read is a harmless repeat.
  function automatic sram_pins_t pins_for(input state_t s);
    sram_pins_t p;
    case (s)
      ST_WRITE:      p = PINS_WRITE;
      ST_RD_ISSUE:   p = PINS_READ;
      ST_RD_CAPTURE: p = PINS_READ;
      default:       p = PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous response FIFO; the head entry is visible on rdata
// without a pop, and push with pop on a full FIFO reuses the popped slot.
module sram_rsp_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [$clog2(RSP_DEPTH+1)-1:0]   count,
  output logic                             empty
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  full, pop_ok, push_ok;
  logic [DATA_WIDTH-1:0] entries [RSP_DEPTH];

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(RSP_DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = count_reg;
  assign rdata   = entries[rd_ptr_reg];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push_ok && wr_ptr_reg == PTR_W'(gi)) begin
          entry_reg <= wdata;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Valid/ready front-end for a single-port 1RW SRAM macro: sequences the
// active-low pins, owns the tri-state data bus and buffers read responses.
module sram_1rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  output logic                  busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  state_t                state_reg, state_next;
  sram_pins_t            pins_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  drive_reg;
  logic                  accept, push, credit, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  assign credit = (fifo_count < CNT_W'(RSP_DEPTH));

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Writes wait for a free slot too, so requests retire strictly in order.
        req_ready = rst_n && credit;
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          state_next = req_we ? ST_WRITE : ST_RD_ISSUE;
        end
      end
      ST_WRITE:      state_next = ST_IDLE;
      ST_RD_ISSUE:   state_next = ST_RD_CAPTURE;
      ST_RD_CAPTURE: begin
        push       = 1'b1;
        state_next = ST_IDLE;
      end
      default:       state_next = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pins_reg  <= PINS_IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      drive_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pins_reg  <= pins_for(state_next);
      drive_reg <= (state_next == ST_WRITE);
      if (accept) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
    end
  end

  assign sram_data = drive_reg ? wdata_reg : 'z;
  assign sram_addr = addr_reg;
  assign sram_csb  = pins_reg.csb;
  assign sram_web  = pins_reg.web;
  assign sram_oeb  = pins_reg.oeb;

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rsp_ready),
    .wdata (sram_data),
    .rdata (rsp_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign busy      = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// Directed bench for sram_1rw_ctrl with a behavioural 1RW macro on the pins.
module tb_sram_1rw_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_we;
  logic [9:0]   req_addr;
  logic [127:0] req_wdata;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_rdata;
  wire  [127:0] sram_data;
  logic [9:0]   sram_addr;
  logic         sram_csb, sram_web, sram_oeb, busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sram_1rw_ctrl #(.DATA_WIDTH(128), .ADDR_WIDTH(10), .RSP_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_data(sram_data), .sram_addr(sram_addr),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .busy(busy)
  );

  // Behavioural macro: writes on the edge with WEb low, loads its output register otherwise.
  logic [127:0] mac_mem [1024];
  logic [127:0] mac_q;
  logic         mac_oe;
  always @(posedge clk) begin
    if (!sram_csb && !sram_web) mac_mem[sram_addr] <= sram_data;
    else if (!sram_csb)         mac_q <= mac_mem[sram_addr];
  end
  assign mac_oe    = !sram_csb && !sram_oeb && sram_web;
  assign sram_data = mac_oe ? mac_q : 'z;

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert (!(!sram_web && mac_oe)) else begin
        failed++;
        $error("FAIL bus_contention: observed web=%0b macro_oe=%0b required no overlap", sram_web, mac_oe);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [9:0] a, input logic [127:0] d);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", (n < 40) ? 128'd1 : 128'd0, 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [9:0] a, input logic [127:0] exp);
    int n;
    n = 0;
    issue(1'b0, a, '0);
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, {127'd0, rsp_valid}, 128'd1);
    check({tag, "_data"}, rsp_rdata, exp);
    pop_one();
  endtask

  localparam logic [127:0] PA5  = {16{8'hA5}};
  localparam logic [127:0] D10  = {4{32'h1010_0001}};
  localparam logic [127:0] D11  = {4{32'h1111_0002}};
  localparam logic [127:0] D12  = {4{32'h1212_0003}};
  localparam logic [127:0] P0   = {4{32'h0000_F00D}};
  localparam logic [127:0] PMAX = {4{32'hFFFF_0BAD}};

  logic [9:0]   ov_addr [5];
  logic [127:0] ov_data [5];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_csb", {127'd0, sram_csb}, 128'd1);
    check("rst_web", {127'd0, sram_web}, 128'd1);
    check("rst_oeb", {127'd0, sram_oeb}, 128'd1);
    check("rst_addr", {118'd0, sram_addr}, 128'd0);
    check("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_req_ready", {127'd0, req_ready}, 128'd0);
    rst_n = 1'b1;

    // Write 0x005 then read it back.
    issue(1'b1, 10'h005, PA5);
    check("wr_web_low", {127'd0, sram_web}, 128'd0);
    check("wr_csb_low", {127'd0, sram_csb}, 128'd0);
    check("wr_oeb_high", {127'd0, sram_oeb}, 128'd1);
    check("wr_addr", {118'd0, sram_addr}, 128'h005);
    check("wr_bus", sram_data, PA5);
    check("wr_busy", {127'd0, busy}, 128'd1);
    @(posedge clk); #1;
    check("wr_web_one_cycle", {127'd0, sram_web}, 128'd1);
    check("wr_csb_release", {127'd0, sram_csb}, 128'd1);
    check("wr_committed", mac_mem[5], PA5);

    issue(1'b0, 10'h005, '0);
    check("rd_csb", {127'd0, sram_csb}, 128'd0);
    check("rd_oeb", {127'd0, sram_oeb}, 128'd0);
    check("rd_web", {127'd0, sram_web}, 128'd1);
    check("rd_valid_e0", {127'd0, rsp_valid}, 128'd0);
    @(posedge clk); #1;
    check("rd_valid_e1", {127'd0, rsp_valid}, 128'd0);
    @(posedge clk); #1;
    check("rd_valid_e2", {127'd0, rsp_valid}, 128'd1);
    check("rd_data_e2", rsp_rdata, PA5);
    pop_one();
    check("rd_popped", {127'd0, rsp_valid}, 128'd0);
    check("rd_idle_busy", {127'd0, busy}, 128'd0);

    // Backpressure: two reads fill the FIFO, the third waits for a pop.
    issue(1'b1, 10'h010, D10);
    issue(1'b1, 10'h011, D11);
    issue(1'b1, 10'h012, D12);
    issue(1'b0, 10'h010, '0);
    issue(1'b0, 10'h011, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h012;
    repeat (3) @(negedge clk);
    check("bp_ready_full", {127'd0, req_ready}, 128'd0);
    check("bp_head_hold", rsp_rdata, D10);
    check("bp_busy", {127'd0, busy}, 128'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_head_second", rsp_rdata, D11);
    @(negedge clk);
    check("bp_ready_after_pop", {127'd0, req_ready}, 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_third_issued", {127'd0, sram_csb}, 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_order_1", rsp_rdata, D11);
    pop_one();
    check("bp_order_2", rsp_rdata, D12);
    check("bp_order_2_valid", {127'd0, rsp_valid}, 128'd1);
    pop_one();
    check("bp_drained", {127'd0, rsp_valid}, 128'd0);

    // Address boundaries with distinct patterns.
    issue(1'b1, 10'h000, P0);
    issue(1'b1, 10'h3FF, PMAX);
    read_check("bnd_lo", 10'h000, P0);
    read_check("bnd_hi", 10'h3FF, PMAX);
    read_check("bnd_lo_again", 10'h000, P0);

    // Back-to-back reads with the consumer always ready.
    ov_addr[0] = 10'h010; ov_data[0] = D10;
    ov_addr[1] = 10'h011; ov_data[1] = D11;
    ov_addr[2] = 10'h012; ov_data[2] = D12;
    ov_addr[3] = 10'h000; ov_data[3] = P0;
    ov_addr[4] = 10'h3FF; ov_data[4] = PMAX;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, ov_addr[i], '0);
      check("ov_prev_popped", {127'd0, rsp_valid}, 128'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("ov_valid", {127'd0, rsp_valid}, 128'd1);
      check("ov_data", rsp_rdata, ov_data[i]);
    end
    @(posedge clk); #1;
    check("ov_drained", {127'd0, rsp_valid}, 128'd0);
    rsp_ready = 1'b0;

    // Reset asserted while the controller is in RD_CAPTURE.
    issue(1'b0, 10'h3FF, '0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("rstmid_ready_low", {127'd0, req_ready}, 128'd0);
    @(posedge clk); #1;
    check("rstmid_csb", {127'd0, sram_csb}, 128'd1);
    check("rstmid_oeb", {127'd0, sram_oeb}, 128'd1);
    check("rstmid_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    check("rstmid_idle", {127'd0, busy}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_check("post_rst", 10'h005, PA5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
